// File: rtl/cpu_interrupt_sequencer.sv
// ============================================================================
// cpu_interrupt_sequencer: 2A03 reset/NMI/IRQ/BRK front-end.
// Runs the 7-cycle push/vector sequence. Optional macro: VECTORED_IRQ_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module cpu_interrupt_sequencer #(
  parameter int          NUM_IRQ      = 2,
  parameter logic [15:0] NMI_VECTOR   = 16'hFFFA,
  parameter logic [15:0] RESET_VECTOR = 16'hFFFC,
  parameter logic [15:0] IRQ_VECTOR   = 16'hFFFE,
  parameter logic [7:0]  STACK_PAGE   = 8'h01
) (
  input  logic               clock,
  input  logic               nreset,
  input  logic               nnmi,
  input  logic [NUM_IRQ-1:0] nirq_src,
  input  logic [NUM_IRQ-1:0] irq_mask,
  input  logic               flag_i,
  input  logic               instr_boundary,
  input  logic               brk_req,
  input  logic [15:0]        pc_in,
  input  logic [7:0]         flags_in,
  input  logic [7:0]         sp_in,
  input  logic [7:0]         data_in,
  output logic               busy,
  output logic [15:0]        bus_addr,
  output logic [7:0]         bus_data_out,
  output logic               bus_rw,
  output logic               sp_load,
  output logic [7:0]         sp_out,
  output logic               pc_load,
  output logic [15:0]        pc_out,
  output logic [NUM_IRQ-1:0] irq_pending
);

  localparam logic [3:0] c_st_idle     = 4'd0;
  localparam logic [3:0] c_st_s0       = 4'd1;
  localparam logic [3:0] c_st_s1       = 4'd2;
  localparam logic [3:0] c_st_s2       = 4'd3;
  localparam logic [3:0] c_st_s3       = 4'd4;
  localparam logic [3:0] c_st_s4       = 4'd5;
  localparam logic [3:0] c_st_s5       = 4'd6;
  localparam logic [3:0] c_st_s6       = 4'd7;
  localparam logic [3:0] c_st_rst_hold = 4'd8;

  localparam logic [1:0] c_cause_reset = 2'd0;
  localparam logic [1:0] c_cause_nmi   = 2'd1;
  localparam logic [1:0] c_cause_irq   = 2'd2;
  localparam logic [1:0] c_cause_brk   = 2'd3;

  logic [3:0]         r_state;
  logic [1:0]         r_cause;
  logic [15:0]        r_ret_pc;
  logic [7:0]         r_flags;
  logic [7:0]         r_sp;
  logic               r_nnmi_prev;
  logic               r_nmi_latch;
  logic               r_nmi_rearm;
  logic [NUM_IRQ-1:0] r_irq_pending;
  logic [15:0]        r_vec;
  logic [7:0]         r_vec_lo;

  logic        w_nmi_edge;
  logic        w_irq_req;
  logic        w_accept;
  logic [1:0]  w_accept_cause;
  logic [15:0] w_irq_vec;
  logic [15:0] w_vector;
  logic        w_vec_is_nmi;
  logic        w_in_push;
  logic [7:0]  w_pushed_p;

  assign w_nmi_edge  = r_nnmi_prev & ~nnmi;
  assign w_irq_req   = (|r_irq_pending) & ~flag_i;
  assign w_accept    = instr_boundary & (r_nmi_latch | w_irq_req | brk_req);
  assign w_in_push   = (r_state == c_st_s2) || (r_state == c_st_s3) || (r_state == c_st_s4);
  assign w_pushed_p  = r_flags | 8'h20 | {3'b000, (r_cause == c_cause_brk), 4'b0000};
  assign irq_pending = r_irq_pending;

  always_comb begin
    w_accept_cause = c_cause_brk;
    if (r_nmi_latch)    w_accept_cause = c_cause_nmi;
    else if (w_irq_req) w_accept_cause = c_cause_irq;
  end

`ifdef VECTORED_IRQ_EN
  logic [2:0] r_irq_idx;
  logic [2:0] w_irq_idx;

  // Lowest-index pending source wins
  always_comb begin
    w_irq_idx = 3'd0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (r_irq_pending[i]) w_irq_idx = 3'(i);
    end
  end

  always_ff @(posedge clock) begin
    if (nreset)
      r_irq_idx <= 3'd0;
    else if (r_state == c_st_idle && w_accept)
      r_irq_idx <= w_irq_idx;
  end

  // Sources above 0 step down past the NMI and reset vector slots
  assign w_irq_vec = IRQ_VECTOR - {12'd0, r_irq_idx, 1'b0}
                     - ((r_irq_idx != 3'd0) ? 16'd4 : 16'd0);
`else
  assign w_irq_vec = IRQ_VECTOR;
`endif

  always_comb begin
    w_vector     = NMI_VECTOR;
    w_vec_is_nmi = 1'b1;
    case (r_cause)
      c_cause_reset: begin
        w_vector     = RESET_VECTOR;
        w_vec_is_nmi = 1'b0;
      end
      c_cause_nmi: ;
      default: begin
        // A pending NMI hijacks an IRQ/BRK sequence up to the vector fetch
        if (!r_nmi_latch) begin
          w_vector     = (r_cause == c_cause_brk) ? IRQ_VECTOR : w_irq_vec;
          w_vec_is_nmi = 1'b0;
        end
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (nreset) begin
      r_state       <= c_st_rst_hold;
      r_cause       <= c_cause_reset;
      r_ret_pc      <= 16'h0000;
      r_flags       <= 8'h00;
      r_sp          <= 8'h00;
      r_nnmi_prev   <= 1'b1;
      r_nmi_latch   <= 1'b0;
      r_nmi_rearm   <= 1'b0;
      r_irq_pending <= '0;
      r_vec         <= 16'h0000;
      r_vec_lo      <= 8'h00;
    end else begin
      r_nnmi_prev   <= nnmi;
      r_irq_pending <= ~nirq_src & irq_mask;

      // A second edge during an NMI sequence must survive the S5 clear
      if (r_state == c_st_s5 && w_vec_is_nmi) begin
        r_nmi_latch <= w_nmi_edge | r_nmi_rearm;
        r_nmi_rearm <= 1'b0;
      end else begin
        if (w_nmi_edge) r_nmi_latch <= 1'b1;
        if (r_state == c_st_idle)
          r_nmi_rearm <= 1'b0;
        else if (w_nmi_edge && r_nmi_latch && r_state != c_st_s6)
          r_nmi_rearm <= 1'b1;
      end

      case (r_state)
        c_st_rst_hold: begin
          r_state <= c_st_s0;
          r_cause <= c_cause_reset;
        end
        c_st_idle: begin
          if (w_accept) begin
            r_state  <= c_st_s0;
            r_cause  <= w_accept_cause;
            r_ret_pc <= (w_accept_cause == c_cause_brk) ? pc_in + 16'd2 : pc_in;
            r_flags  <= flags_in & 8'hCF;
            r_sp     <= sp_in;
          end
        end
        c_st_s0, c_st_s1: r_state <= r_state + 4'd1;
        c_st_s2, c_st_s3, c_st_s4: begin
          r_sp    <= r_sp - 8'd1;
          r_state <= r_state + 4'd1;
        end
        c_st_s5: begin
          r_vec    <= w_vector;
          r_vec_lo <= data_in;
          r_state  <= c_st_s6;
        end
        default: r_state <= c_st_idle;
      endcase
    end
  end

  always_comb begin
    busy         = 1'b1;
    bus_addr     = 16'h0000;
    bus_data_out = 8'h00;
    bus_rw       = 1'b1;
    sp_load      = 1'b0;
    sp_out       = r_sp;
    pc_load      = 1'b0;
    pc_out       = 16'h0000;
    if (w_in_push) begin
      bus_addr = {STACK_PAGE, r_sp};
      sp_load  = 1'b1;
      sp_out   = r_sp - 8'd1;
      // Reset walks the stack pointer but never writes
      bus_rw   = (r_cause == c_cause_reset);
    end
    case (r_state)
      c_st_rst_hold: ;
      c_st_s0, c_st_s1: bus_addr = r_ret_pc;
      c_st_s2: if (!bus_rw) bus_data_out = r_ret_pc[15:8];
      c_st_s3: if (!bus_rw) bus_data_out = r_ret_pc[7:0];
      c_st_s4: if (!bus_rw) bus_data_out = w_pushed_p;
      c_st_s5: bus_addr = w_vector;
      c_st_s6: begin
        bus_addr = r_vec + 16'd1;
        pc_load  = 1'b1;
        pc_out   = {data_in, r_vec_lo};
      end
      default: busy = 1'b0;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_cpu_interrupt_sequencer.sv
// ============================================================================
// tb_cpu_interrupt_sequencer: directed self-checking bench for the sequencer.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_cpu_interrupt_sequencer;

  logic        clock = 1'b0;
  logic        nreset;
  logic        nnmi;
  logic [1:0]  nirq_src;
  logic [1:0]  irq_mask;
  logic        flag_i;
  logic        instr_boundary;
  logic        brk_req;
  logic [15:0] pc_in;
  logic [7:0]  flags_in;
  logic [7:0]  sp_in;
  logic [7:0]  data_in;
  logic        busy;
  logic [15:0] bus_addr;
  logic [7:0]  bus_data_out;
  logic        bus_rw;
  logic        sp_load;
  logic [7:0]  sp_out;
  logic        pc_load;
  logic [15:0] pc_out;
  logic [1:0]  irq_pending;

  logic [7:0] mem [0:65535];
  int n_pass = 0;
  int n_total = 0;

  int          cap_busy, cap_wr, cap_pc_seen;
  logic        cap_timeout;
  logic [15:0] cap_wa [3];
  logic [7:0]  cap_wd [3];
  logic [7:0]  cap_sp;
  logic [15:0] cap_pc, cap_vec, prev_addr;

  always #5 clock = ~clock;

  assign data_in = bus_rw ? mem[bus_addr] : 8'h00;

  cpu_interrupt_sequencer #(.NUM_IRQ(2)) dut (
    .clock(clock), .nreset(nreset), .nnmi(nnmi), .nirq_src(nirq_src),
    .irq_mask(irq_mask), .flag_i(flag_i), .instr_boundary(instr_boundary),
    .brk_req(brk_req), .pc_in(pc_in), .flags_in(flags_in), .sp_in(sp_in),
    .data_in(data_in), .busy(busy), .bus_addr(bus_addr),
    .bus_data_out(bus_data_out), .bus_rw(bus_rw), .sp_load(sp_load),
    .sp_out(sp_out), .pc_load(pc_load), .pc_out(pc_out),
    .irq_pending(irq_pending)
  );

  // Records one busy window; nmi_at >= 0 drops nnmi during that busy cycle
  task automatic capture(input int nmi_at);
    int t;
    t = 0; cap_busy = 0; cap_wr = 0; cap_pc_seen = 0;
    cap_sp = 8'hxx; cap_pc = 16'hxxxx; cap_vec = 16'hxxxx; prev_addr = 16'hxxxx;
    while (busy !== 1'b1 && t < 6) begin
      @(negedge clock);
      t++;
    end
    cap_timeout = (busy !== 1'b1);
    while (busy === 1'b1 && cap_busy < 20) begin
      if (nmi_at >= 0 && cap_busy == nmi_at) nnmi = 1'b0;
      if (nmi_at >= 0 && cap_busy == nmi_at + 2) nnmi = 1'b1;
      if (bus_rw === 1'b0) begin
        if (cap_wr < 3) begin
          cap_wa[cap_wr] = bus_addr;
          cap_wd[cap_wr] = bus_data_out;
        end
        cap_wr++;
      end
      if (sp_load === 1'b1) cap_sp = sp_out;
      if (pc_load === 1'b1) begin
        cap_pc_seen++;
        cap_pc  = pc_out;
        cap_vec = prev_addr;
      end
      prev_addr = bus_addr;
      cap_busy++;
      @(negedge clock);
    end
  endtask

  task automatic pulse_boundary();
    instr_boundary = 1'b1;
    @(negedge clock);
    instr_boundary = 1'b0;
    brk_req        = 1'b0;
  endtask

  task automatic test_reset();
    nreset = 1'b1; nnmi = 1'b1; nirq_src = 2'b00; irq_mask = 2'b11;
    flag_i = 1'b0; instr_boundary = 1'b0; brk_req = 1'b0;
    pc_in = 16'h1234; flags_in = 8'h00; sp_in = 8'h55;
    repeat (3) @(negedge clock);
    n_total++; if (busy !== 1'b1) $display("FAIL reset_busy: got %b want 1", busy); else n_pass++;
    n_total++; if (bus_rw !== 1'b1) $display("FAIL reset_rw: got %b want 1", bus_rw); else n_pass++;
    n_total++; if (bus_addr !== 16'h0000) $display("FAIL reset_addr: got %h want 0000", bus_addr); else n_pass++;
    n_total++; if (irq_pending !== 2'b00) $display("FAIL reset_pending: got %b want 00", irq_pending); else n_pass++;
    n_total++; if ({sp_load, pc_load} !== 2'b00) $display("FAIL reset_loads: got %b want 00", {sp_load, pc_load}); else n_pass++;
    n_total++; if (bus_data_out !== 8'h00) $display("FAIL reset_data: got %h want 00", bus_data_out); else n_pass++;
    nirq_src = 2'b11;
    nreset   = 1'b0;
    @(negedge clock);
    capture(-1);
    n_total++; if (cap_busy !== 7) $display("FAIL rst_seq_len: got %0d want 7", cap_busy); else n_pass++;
    n_total++; if (cap_wr !== 0) $display("FAIL rst_seq_writes: got %0d want 0", cap_wr); else n_pass++;
    n_total++; if (cap_sp !== 8'hFD) $display("FAIL rst_seq_sp: got %h want FD", cap_sp); else n_pass++;
    n_total++; if (cap_pc_seen !== 1) $display("FAIL rst_seq_pcload: got %0d want 1", cap_pc_seen); else n_pass++;
    n_total++; if (cap_pc !== 16'hC000) $display("FAIL rst_seq_pc: got %h want C000", cap_pc); else n_pass++;
    n_total++; if (cap_vec !== 16'hFFFC) $display("FAIL rst_seq_vec: got %h want FFFC", cap_vec); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL rst_seq_idle: got %b want 0", busy); else n_pass++;
  endtask

  task automatic test_irq();
    nirq_src = 2'b10; irq_mask = 2'b01; flag_i = 1'b0;
    pc_in = 16'h8123; sp_in = 8'hFF; flags_in = 8'h00;
    @(negedge clock);
    n_total++; if (irq_pending !== 2'b01) $display("FAIL irq_pending: got %b want 01", irq_pending); else n_pass++;
    pulse_boundary();
    capture(-1);
    n_total++; if (cap_timeout !== 1'b0) $display("FAIL irq_start: got timeout %b want 0", cap_timeout); else n_pass++;
    n_total++; if (cap_busy !== 7) $display("FAIL irq_len: got %0d want 7", cap_busy); else n_pass++;
    n_total++; if (cap_wr !== 3) $display("FAIL irq_writes: got %0d want 3", cap_wr); else n_pass++;
    n_total++; if ({cap_wa[0], cap_wd[0]} !== 24'h01FF81) $display("FAIL irq_push_pch: got %h@%h want 81@01FF", cap_wd[0], cap_wa[0]); else n_pass++;
    n_total++; if ({cap_wa[1], cap_wd[1]} !== 24'h01FE23) $display("FAIL irq_push_pcl: got %h@%h want 23@01FE", cap_wd[1], cap_wa[1]); else n_pass++;
    n_total++; if ({cap_wa[2], cap_wd[2]} !== 24'h01FD20) $display("FAIL irq_push_p: got %h@%h want 20@01FD", cap_wd[2], cap_wa[2]); else n_pass++;
    n_total++; if (cap_sp !== 8'hFC) $display("FAIL irq_sp: got %h want FC", cap_sp); else n_pass++;
    n_total++; if (cap_pc !== 16'hE234) $display("FAIL irq_pc: got %h want E234", cap_pc); else n_pass++;
    n_total++; if (cap_vec !== 16'hFFFE) $display("FAIL irq_vec: got %h want FFFE", cap_vec); else n_pass++;
    nirq_src = 2'b11;
    @(negedge clock);
  endtask

  task automatic test_irq_inhibited();
    flag_i = 1'b1; nirq_src = 2'b10; irq_mask = 2'b01;
    @(negedge clock);
    n_total++; if (irq_pending !== 2'b01) $display("FAIL iflag_pending: got %b want 01", irq_pending); else n_pass++;
    pulse_boundary();
    capture(-1);
    n_total++; if (cap_timeout !== 1'b1) $display("FAIL iflag_no_seq: got timeout %b want 1", cap_timeout); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL iflag_busy: got %b want 0", busy); else n_pass++;
    nirq_src = 2'b11; flag_i = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_nmi_held();
    int seqs, wr;
    logic [7:0] p;
    logic [15:0] pc, vec, prev;
    seqs = 0; wr = 0; p = 8'hxx; pc = 16'hxxxx; vec = 16'hxxxx; prev = 16'hxxxx;
    flags_in = 8'h00; sp_in = 8'hFF; pc_in = 16'h4000;
    nnmi = 1'b0;
    instr_boundary = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (bus_rw === 1'b0) begin
        wr++;
        p = bus_data_out;
      end
      if (pc_load === 1'b1) begin
        seqs++;
        pc  = pc_out;
        vec = prev;
      end
      prev = bus_addr;
    end
    instr_boundary = 1'b0;
    nnmi = 1'b1;
    n_total++; if (seqs !== 1) $display("FAIL nmi_held_count: got %0d want 1", seqs); else n_pass++;
    n_total++; if (vec !== 16'hFFFA) $display("FAIL nmi_held_vec: got %h want FFFA", vec); else n_pass++;
    n_total++; if (pc !== 16'hD011) $display("FAIL nmi_held_pc: got %h want D011", pc); else n_pass++;
    n_total++; if (wr !== 3) $display("FAIL nmi_held_writes: got %0d want 3", wr); else n_pass++;
    n_total++; if (p !== 8'h20) $display("FAIL nmi_held_p: got %h want 20", p); else n_pass++;
    @(negedge clock);
  endtask

  task automatic test_brk_hijack();
    pc_in = 16'h9000; sp_in = 8'hFF; flags_in = 8'h00;
    brk_req = 1'b1;
    pulse_boundary();
    capture(3);
    n_total++; if ({cap_wa[0], cap_wd[0]} !== 24'h01FF90) $display("FAIL brk_push_pch: got %h@%h want 90@01FF", cap_wd[0], cap_wa[0]); else n_pass++;
    n_total++; if ({cap_wa[1], cap_wd[1]} !== 24'h01FE02) $display("FAIL brk_push_pcl: got %h@%h want 02@01FE", cap_wd[1], cap_wa[1]); else n_pass++;
    n_total++; if ({cap_wa[2], cap_wd[2]} !== 24'h01FD30) $display("FAIL brk_push_p: got %h@%h want 30@01FD", cap_wd[2], cap_wa[2]); else n_pass++;
    n_total++; if (cap_vec !== 16'hFFFA) $display("FAIL brk_hijack_vec: got %h want FFFA", cap_vec); else n_pass++;
    n_total++; if (cap_pc !== 16'hD011) $display("FAIL brk_hijack_pc: got %h want D011", cap_pc); else n_pass++;
    n_total++; if (cap_sp !== 8'hFC) $display("FAIL brk_sp: got %h want FC", cap_sp); else n_pass++;
    pulse_boundary();
    capture(-1);
    n_total++; if (cap_timeout !== 1'b1) $display("FAIL brk_nmi_consumed: got timeout %b want 1", cap_timeout); else n_pass++;
  endtask

  task automatic test_nmi_over_irq();
    flags_in = 8'h00; sp_in = 8'hFF; pc_in = 16'h5000;
    nnmi = 1'b0; nirq_src = 2'b10; irq_mask = 2'b01; flag_i = 1'b0;
    @(negedge clock);
    pulse_boundary();
    capture(-1);
    n_total++; if (cap_vec !== 16'hFFFA) $display("FAIL prio_first_vec: got %h want FFFA", cap_vec); else n_pass++;
    n_total++; if (cap_wd[2] !== 8'h20) $display("FAIL prio_first_p: got %h want 20", cap_wd[2]); else n_pass++;
    pulse_boundary();
    capture(-1);
    n_total++; if (cap_vec !== 16'hFFFE) $display("FAIL prio_second_vec: got %h want FFFE", cap_vec); else n_pass++;
    n_total++; if (cap_pc !== 16'hE234) $display("FAIL prio_second_pc: got %h want E234", cap_pc); else n_pass++;
    nirq_src = 2'b11; nnmi = 1'b1;
    @(negedge clock);
  endtask

  task automatic test_irq_source1();
    logic [15:0] exp_vec, exp_pc;
`ifdef VECTORED_IRQ_EN
    exp_vec = 16'hFFF8; exp_pc = 16'h5678;
`else
    exp_vec = 16'hFFFE; exp_pc = 16'hE234;
`endif
    nirq_src = 2'b01; irq_mask = 2'b11; flag_i = 1'b0;
    @(negedge clock);
    n_total++; if (irq_pending !== 2'b10) $display("FAIL src1_pending: got %b want 10", irq_pending); else n_pass++;
    pulse_boundary();
    capture(-1);
    n_total++; if (cap_vec !== exp_vec) $display("FAIL src1_vec: got %h want %h", cap_vec, exp_vec); else n_pass++;
    n_total++; if (cap_pc !== exp_pc) $display("FAIL src1_pc: got %h want %h", cap_pc, exp_pc); else n_pass++;
    nirq_src = 2'b11;
    @(negedge clock);
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    mem[16'hFFFA] = 8'h11; mem[16'hFFFB] = 8'hD0;
    mem[16'hFFFC] = 8'h00; mem[16'hFFFD] = 8'hC0;
    mem[16'hFFFE] = 8'h34; mem[16'hFFFF] = 8'hE2;
    mem[16'hFFF8] = 8'h78; mem[16'hFFF9] = 8'h56;
    test_reset();
    test_irq();
    test_irq_inhibited();
    test_nmi_held();
    test_brk_hijack();
    test_nmi_over_irq();
    test_irq_source1();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire

// File: doc/cpu_interrupt_sequencer.md
Name: cpu_interrupt_sequencer

Overview:
Parametrised interrupt/reset front-end for the 2A03 core, generalising the single nnmi/nirq pins to NUM_IRQ maskable IRQ sources plus NMI, BRK and reset. At an instruction boundary it accepts the highest-priority request and takes the bus. It then runs the 7-cycle 6502 stack-push/vector-fetch sequence and hands the core a new PC, SP and I flag. It sits beside the control ROM and owns the address/data mux while busy.

Parameters:
NUM_IRQ, 2, number of active-low IRQ sources (1..8)
NMI_VECTOR, 16'hFFFA, NMI vector low-byte address
RESET_VECTOR, 16'hFFFC, reset vector low-byte address
IRQ_VECTOR, 16'hFFFE, IRQ/BRK vector low-byte address
STACK_PAGE, 8'h01, stack high byte

Ports:
clock  in  1  system clock
nreset  in  1  reset, synchronous, active-high
nnmi  in  1  NMI, active-low, falling-edge sensitive
nirq_src  in  NUM_IRQ  IRQ sources, active-low, level
irq_mask  in  NUM_IRQ  1 = source enabled
flag_i  in  1  core I flag
instr_boundary  in  1  core is at opcode fetch this cycle
brk_req  in  1  core decoded BRK (qualified by instr_boundary)
pc_in  in  16  core PC (return address)
flags_in  in  8  core P register
sp_in  in  8  core SP
data_in  in  8  bus read data
busy  out  1  sequencer owns bus; core stalls
bus_addr  out  16  address while busy
bus_data_out  out  8  write data while busy
bus_rw  out  1  1=read, 0=write
sp_load  out  1  pulse: core loads sp_out
sp_out  out  8  updated SP
pc_load  out  1  pulse: core loads pc_out, sets I
pc_out  out  16  vector target
irq_pending  out  NUM_IRQ  registered ~nirq_src & irq_mask

Behaviour:
- States: IDLE, S0..S6, RST_HOLD. Cause register: RESET, NMI, IRQ, BRK.
- While nreset=1: state=RST_HOLD, busy=1, bus_rw=1, bus_addr=0, bus_data_out=0, sp_load=0, pc_load=0, nmi_latch=0, irq_pending=0, internal sp=0. First cycle after release: S0 with cause=RESET.
- nnmi is sampled every cycle. A 1->0 transition sets nmi_latch. Holding nnmi low does not retrigger. nmi_latch clears in the S5 cycle of any sequence whose vector is NMI_VECTOR.
- Accept in IDLE when instr_boundary=1, priority NMI (nmi_latch) > IRQ (|irq_pending & ~flag_i) > BRK (brk_req). Next cycle is S0 with busy=1. Latch pc_in, flags_in, sp_in at accept. For BRK, the latched return PC is pc_in+2.
- S0 and S1: dummy read at latched PC.
- S2: push PCH. S3: push PCL. S4: push P.
  - Push address = {STACK_PAGE, sp}; sp decrements by 1 per push.
  - sp_load=1 with sp_out = new sp on each push cycle.
  - Pushed P: bit5=1; bit4=1 for BRK only (0 for IRQ/NMI).
- Cause RESET: S2..S4 are reads (bus_rw=1, no data), but sp still decrements, so SP wraps 00->FD.
- S5: read vector low byte.
- S6: read vector+1. pc_load=1 for exactly this cycle with pc_out = {data_in, low}. Return to IDLE; busy=0 the next cycle.
- NMI hijack: an nmi_latch that is set at or before S4 of an IRQ/BRK sequence switches the vector to NMI_VECTOR. The pushed B bit is unchanged.
- NMI edges during an NMI/reset sequence stay latched and are serviced at the next boundary.
- IRQ is level-sensitive and is not latched. A deasserted source before accept means no sequence.
- vector+1 wraps within 16 bits.

Optional Feature:
VECTORED_IRQ_EN:
- Defined: IRQ cause uses the lowest-index pending enabled source k, captured at accept. Vector = IRQ_VECTOR - 2*(k+NMI_SLOTS), where k=0 maps to IRQ_VECTOR itself (effective vector IRQ_VECTOR-2k for k>0 skipping 0xFFFA/0xFFFC, i.e. IRQ_VECTOR-6-2*(k-1)). BRK always uses IRQ_VECTOR.
- Undefined: all IRQ sources use IRQ_VECTOR.

Test Plan:
- Reset high 3 cycles, then release; mem[FFFC]=00, mem[FFFD]=C0, sp_in ignored -> 7 busy cycles, no writes, final sp_out=FD, pc_load with pc_out=C000.
- IRQ: nirq_src[0]=0, mask=01, flag_i=0, pc_in=8123, sp_in=FF, flags_in=00.
  - Response: writes 81@01FF, 23@01FE, 20@01FD; sp_out=FC; pc_out=mem[FFFF:FFFE].
- Same IRQ with flag_i=1 -> no sequence, busy stays 0, irq_pending=01.
- nnmi falls once and is held low 20 cycles -> exactly one NMI sequence, vector FFFA, nmi_latch cleared at S5.
- BRK with pc_in=9000 and an NMI edge during S3 -> pushes 90,02, P with bit4=1, then vector FFFA.
- NMI and IRQ pending at the same boundary -> NMI serviced first. IRQ is serviced at the next boundary if flag_i=0. With VECTORED_IRQ_EN and source 1 only pending -> vector FFF8.
